// File: rtl/rosc_meas_ctrl_pkg.sv
// Shared constants for the ring-oscillator measurement sequencer: parameter defaults
// and the FSM state encoding.
package rosc_meas_ctrl_pkg;

   localparam int HOLD_CYCLES_DEF   = 4;
   localparam int SETTLE_CYCLES_DEF = 4;
   localparam int GATE_W_DEF        = 24;
   localparam int MAX_RETRY_DEF     = 8;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_CLEAR   = 3'd1;
   localparam state_t ST_START   = 3'd2;
   localparam state_t ST_GATE    = 3'd3;
   localparam state_t ST_STOP    = 3'd4;
   localparam state_t ST_SETTLE  = 3'd5;
   localparam state_t ST_CAPTURE = 3'd6;
   localparam state_t ST_PRESENT = 3'd7;

endpackage

// File: rtl/rosc_meas_ctrl_if.sv
// Result handshake between the measurement sequencer (master) and the readout logic (slave).
interface rosc_meas_ctrl_if;

   logic [31:0] result;
   logic        result_err;
   logic        result_valid;
   logic        result_ready;

   modport master (output result, result_err, result_valid, input result_ready);
   modport slave  (input result, result_err, result_valid, output result_ready);

endinterface

// File: rtl/rosc_cmd_hold.sv
// Stretches a one-cycle request into a registered level held for HOLD_CYCLES clk cycles,
// long enough for the timer to sample it on its own oscillator edge.
module rosc_cmd_hold
   import rosc_meas_ctrl_pkg::*;
#(
   parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pulse,
   output logic level
);

   localparam int CW = $clog2(HOLD_CYCLES + 1);

   logic [CW-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level <= 1'b0;
         cnt   <= '0;
      end else if (pulse) begin
         level <= 1'b1;
         cnt   <= CW'(HOLD_CYCLES - 1);
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end else begin
         level <= 1'b0;
      end
   end

endmodule

// File: rtl/rosc_meas_ctrl.sv
// Sequencer for the ring-oscillator timer: clear/start/gate/stop, then a two-sample
// stability capture of the asynchronous count, presented on a valid/ready port.
module rosc_meas_ctrl
   import rosc_meas_ctrl_pkg::*;
#(
   parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
   parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
   parameter int GATE_W        = GATE_W_DEF,
   parameter int MAX_RETRY     = MAX_RETRY_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              go,
   input  logic              continuous,
   input  logic [GATE_W-1:0] gate_cycles,
   output logic              timer_clear,
   output logic              timer_start,
   output logic              timer_stop,
   input  logic [31:0]       elapsed_count,
   output logic              busy,
   rosc_meas_ctrl_if.master  res
);

   typedef logic [GATE_W-1:0] cnt_t;

   localparam cnt_t HOLD_LOAD   = cnt_t'(HOLD_CYCLES - 1);
   localparam cnt_t SETTLE_LOAD = cnt_t'(SETTLE_CYCLES - 1);
   // Two priming cycles fill s0/s1 before the first of MAX_RETRY comparisons.
   localparam cnt_t CAP_LOAD    = cnt_t'(MAX_RETRY + 2);
   localparam cnt_t CAP_CMP     = cnt_t'(MAX_RETRY);
   localparam cnt_t CNT_ONE     = cnt_t'(1);

   state_t      state, state_nxt;
   cnt_t        cnt, cnt_nxt;
   cnt_t        gate_len;
   logic [31:0] s0, s1;
   logic [31:0] result_q;
   logic        err_q;
   logic        cnt_zero;
   logic        samples_match;

   assign cnt_zero      = (cnt == '0);
   assign samples_match = (s0 == s1);

   // NOTE: defaults first so every path assigns state_nxt/cnt_nxt and no latch is inferred.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt_zero ? cnt : cnt - 1'b1;
      case (state)
         ST_IDLE: if (go) begin
            state_nxt = ST_CLEAR;
            cnt_nxt   = HOLD_LOAD;
         end
         ST_CLEAR: if (cnt_zero) begin
            state_nxt = ST_START;
            cnt_nxt   = HOLD_LOAD;
         end
         ST_START: if (cnt_zero) begin
            state_nxt = ST_GATE;
            cnt_nxt   = gate_len - 1'b1;
         end
         ST_GATE: if (cnt_zero) begin
            state_nxt = ST_STOP;
            cnt_nxt   = HOLD_LOAD;
         end
         ST_STOP: if (cnt_zero) begin
            state_nxt = ST_SETTLE;
            cnt_nxt   = SETTLE_LOAD;
         end
         ST_SETTLE: if (cnt_zero) begin
            state_nxt = ST_CAPTURE;
            cnt_nxt   = CAP_LOAD;
         end
         ST_CAPTURE: if (cnt <= CAP_CMP && (samples_match || cnt == CNT_ONE)) begin
            state_nxt = ST_PRESENT;
         end
         ST_PRESENT: if (res.result_ready) begin
            state_nxt = continuous ? ST_CLEAR : ST_IDLE;
            cnt_nxt   = HOLD_LOAD;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         gate_len <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (state == ST_IDLE && go)
            gate_len <= (gate_cycles == '0) ? cnt_t'(1) : gate_cycles;
      end
   end

   // s0 samples the asynchronous bus and gets a full cycle to resolve before it is compared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0       <= '0;
         s1       <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else if (state == ST_CAPTURE) begin
         s0 <= elapsed_count;
         s1 <= s0;
         if (state_nxt == ST_PRESENT) begin
            result_q <= s0;
            err_q    <= !samples_match;
         end
      end
   end

   rosc_cmd_hold #(.HOLD_CYCLES(HOLD_CYCLES)) u_clear (
      .clk   (clk),
      .rst_n (rst_n),
      .pulse (state_nxt == ST_CLEAR && state != ST_CLEAR),
      .level (timer_clear)
   );

   rosc_cmd_hold #(.HOLD_CYCLES(HOLD_CYCLES)) u_start (
      .clk   (clk),
      .rst_n (rst_n),
      .pulse (state_nxt == ST_START && state != ST_START),
      .level (timer_start)
   );

   rosc_cmd_hold #(.HOLD_CYCLES(HOLD_CYCLES)) u_stop (
      .clk   (clk),
      .rst_n (rst_n),
      .pulse (state_nxt == ST_STOP && state != ST_STOP),
      .level (timer_stop)
   );

   assign busy             = (state != ST_IDLE);
   assign res.result       = result_q;
   assign res.result_err   = err_q;
   assign res.result_valid = (state == ST_PRESENT);

endmodule

// File: tb/tb_rosc_meas_ctrl.sv
// Directed bench for rosc_meas_ctrl: a behavioural timer counting 3 per clk while started,
// a table of single measurements, and hand-written hold-off, continuous and reset sequences.
module tb_rosc_meas_ctrl;

   localparam int HOLD = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        go = 1'b0;
   logic        continuous = 1'b0;
   logic [23:0] gate_cycles = '0;
   logic        timer_clear, timer_start, timer_stop;
   logic [31:0] elapsed_count;
   logic        busy;

   rosc_meas_ctrl_if res_if ();

   rosc_meas_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .go            (go),
      .continuous    (continuous),
      .gate_cycles   (gate_cycles),
      .timer_clear   (timer_clear),
      .timer_start   (timer_start),
      .timer_stop    (timer_stop),
      .elapsed_count (elapsed_count),
      .busy          (busy),
      .res           (res_if)
   );

   always #5 clk = ~clk;

   // Timer model: counts while start is seen and afterwards until stop; ignores system reset.
   logic [31:0] tmr_cnt = '0;
   logic        tmr_run = 1'b0;
   logic        tog = 1'b0;
   logic        tog_en = 1'b0;

   always @(posedge clk) begin
      tog <= ~tog;
      if (timer_clear) begin
         tmr_cnt <= '0;
         tmr_run <= 1'b0;
      end else if (timer_start) begin
         tmr_run <= 1'b1;
         tmr_cnt <= tmr_cnt + 32'd3;
      end else if (timer_stop) begin
         tmr_run <= 1'b0;
      end else if (tmr_run) begin
         tmr_cnt <= tmr_cnt + 32'd3;
      end
   end

   assign elapsed_count = tmr_cnt ^ {31'b0, tog_en & tog};

   // Command monitor: width of the last completed high run per command, one-hot violations.
   int run_clr = 0, run_sta = 0, run_stp = 0;
   int w_clr = 0, w_sta = 0, w_stp = 0;
   int n_clr = 0;
   int onehot_bad = 0;

   always @(negedge clk) begin
      if (int'(timer_clear) + int'(timer_start) + int'(timer_stop) > 1) onehot_bad++;
      if (timer_clear) run_clr++;
      else if (run_clr != 0) begin w_clr = run_clr; run_clr = 0; n_clr++; end
      if (timer_start) run_sta++;
      else if (run_sta != 0) begin w_sta = run_sta; run_sta = 0; end
      if (timer_stop) run_stp++;
      else if (run_stp != 0) begin w_stp = run_stp; run_stp = 0; end
   end

   int n_checks = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic start_go(input logic [23:0] g);
      @(negedge clk);
      go = 1'b1;
      gate_cycles = g;
      @(posedge clk);
      #1 go = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         #1 lat++;
      end while (!res_if.result_valid && lat < 3000);
   endtask

   typedef struct {
      logic [23:0] gate;
      int          lat;
      logic [31:0] result;
      logic        err;
   } vec_t;

   vec_t vecs[5];

   task automatic run_vec(input vec_t v, input string tag);
      int lat;
      start_go(v.gate);
      wait_valid(lat);
      check({tag, " latency"}, lat, v.lat);
      check({tag, " result"}, res_if.result, v.result);
      check({tag, " err"}, res_if.result_err, v.err);
      check({tag, " clear width"}, w_clr, HOLD);
      check({tag, " start width"}, w_sta, HOLD);
      check({tag, " stop width"}, w_stp, HOLD);
      res_if.result_ready = 1'b1;
      @(posedge clk);
      #1 res_if.result_ready = 1'b0;
      check({tag, " valid/busy after handshake"}, {res_if.result_valid, busy}, 2'b00);
   endtask

   initial begin
      int lat;
      int bad;
      logic [31:0] snap;
      int clr_before;

      // Latency = 3*HOLD + max(gate,1) + SETTLE + 2 + 1; count = 3*(max(gate,1) + HOLD).
      vecs[0] = '{gate: 24'd100, lat: 119, result: 32'd312, err: 1'b0};
      vecs[1] = '{gate: 24'd0,   lat: 20,  result: 32'd15,  err: 1'b0};
      vecs[2] = '{gate: 24'd1,   lat: 20,  result: 32'd15,  err: 1'b0};
      vecs[3] = '{gate: 24'd7,   lat: 26,  result: 32'd33,  err: 1'b0};
      vecs[4] = '{gate: 24'd255, lat: 274, result: 32'd777, err: 1'b0};

      res_if.result_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset outputs", {timer_clear, timer_start, timer_stop, busy,
                              res_if.result_valid, res_if.result_err, res_if.result}, '0);
      @(negedge clk) rst_n = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Unstable bus: every CAPTURE sample differs, so all 8 comparisons miss.
      tog_en = 1'b1;
      start_go(24'd10);
      wait_valid(lat);
      check("unstable latency", lat, 36);
      check("unstable err", res_if.result_err, 1'b1);
      check("unstable result", res_if.result | 32'd1, 32'd43);
      res_if.result_ready = 1'b1;
      @(posedge clk);
      #1 res_if.result_ready = 1'b0;
      tog_en = 1'b0;
      check("unstable handshake", {res_if.result_valid, busy}, 2'b00);

      // Back-pressure: result held, no re-arm, go ignored while presenting.
      start_go(24'd5);
      wait_valid(lat);
      check("hold latency", lat, 24);
      snap = res_if.result;
      clr_before = n_clr;
      bad = 0;
      go = 1'b1;
      repeat (50) begin
         @(posedge clk);
         #1;
         if (!res_if.result_valid || res_if.result !== snap || res_if.result_err !== 1'b0
             || timer_clear) bad++;
      end
      go = 1'b0;
      check("hold result", snap, 32'd27);
      check("hold stable cycles bad", bad, 0);
      res_if.result_ready = 1'b1;
      @(posedge clk);
      #1 res_if.result_ready = 1'b0;
      check("hold released to idle", {busy, res_if.result_valid, timer_clear}, 3'b000);
      check("hold no new clear", n_clr, clr_before);

      // Continuous: re-arm on handshake, then drop continuous to stop after the next result.
      continuous = 1'b1;
      res_if.result_ready = 1'b1;
      start_go(24'd4);
      wait_valid(lat);
      check("cont first latency", lat, 23);
      check("cont first result", res_if.result, 32'd24);
      @(posedge clk);
      #1;
      check("cont clear after handshake", {timer_clear, busy, res_if.result_valid}, 3'b110);
      wait_valid(lat);
      check("cont second latency", lat, 23);
      check("cont second result", res_if.result, 32'd24);
      continuous = 1'b0;
      @(posedge clk);
      #1;
      check("cont stop to idle", {busy, res_if.result_valid, timer_clear}, 3'b000);
      res_if.result_ready = 1'b0;

      // Asynchronous reset during GATE, STOP and PRESENT.
      start_go(24'd100);
      repeat (20) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check("reset in gate", {busy, timer_clear, timer_start, timer_stop,
                                 res_if.result_valid}, 5'b0);
      @(negedge clk) rst_n = 1'b1;

      start_go(24'd20);
      repeat (29) @(posedge clk);
      #1 check("stop asserted before reset", timer_stop, 1'b1);
      #2 rst_n = 1'b0;
      #1 check("reset in stop", {busy, timer_stop}, 2'b00);
      @(negedge clk) rst_n = 1'b1;

      start_go(24'd20);
      wait_valid(lat);
      check("pre-reset present latency", lat, 39);
      #3 rst_n = 1'b0;
      #1 check("reset in present", {busy, res_if.result_valid, res_if.result_err,
                                    res_if.result}, '0);
      @(negedge clk) rst_n = 1'b1;

      run_vec(vecs[0], "post-reset");
      check("commands one-hot", onehot_bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
